fu_cdb_request_queue: RTL and testbench
=======================================

// Module: fu_cdb_request_queue
// PURPOSE
// - Transmit side of the common-data-bus protocol: one instance sits between a functional unit (ALU, branch) and the CDB arbiter.
// - Buffers completed results {result, ROB tag} in a small FIFO and presents the oldest entry as a bus request.
// - Pops an entry when the arbiter grants the bus; back-pressures the functional unit when full.
// - Flushes all entries on a pipeline squash.
// PARAMETERS
// - WIDTH  31  MSB index of result (result is WIDTH+1 bits)
// - ROB    2   MSB index of ROB tag
// - DEPTH  4   queue entries; power of two, >= 2
// PORTS
// - clk         in   1        clock; all state updates on rising edge
// - clear       in   1        synchronous reset, active-high
// - flush       in   1        squash: discard every queued entry
// - fuValid     in   1        functional unit presents a completed result this cycle
// - fuResult    in   WIDTH+1  completed result value
// - fuRob       in   ROB+1    ROB entry the result belongs to
// - fuReady     out  1        queue accepts fuValid this cycle
// - request     out  1        CDB request to arbiter (e.g. ALURequest)
// - result      out  WIDTH+1  head result driven toward the arbiter (e.g. ALUResult)
// - robEntry    out  ROB+1    head ROB tag (e.g. ALURob)
// - available   in   1        arbiter grant for this unit (e.g. aluAvailable)
// - occupancy   out  $clog2(DEPTH)+1  current entry count
// BEHAVIOUR
// - Reset: clear=1 at posedge -> head/tail pointers 0, occupancy 0, all valid bits 0; request=0, result=0, robEntry=0, fuReady=1.
// - Storage: circular buffer of DEPTH entries, head/tail pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally.
// - Request: request = (occupancy != 0); result/robEntry = head entry, combinational from registers; 0 when empty.
// - Grant: request & available in cycle N -> head is on the CDB in cycle N; head pointer advances and occupancy decrements at the end of cycle N.
// - available with request=0 is ignored: no pop, no state change.
// - Enqueue: fuValid & fuReady -> entry written at tail at posedge, tail advances, occupancy increments.
// - fuReady = (occupancy < DEPTH) | (request & available): a full queue accepts an entry in the same cycle that it pops one.
// - Simultaneous enqueue and pop: occupancy unchanged, both pointers advance.
// - Empty: latency fuValid -> request is 1 cycle (entry registered first).
// - Ordering: strict FIFO; entries leave in arrival order, with no reordering by ROB tag.
// - fuValid while fuReady=0: entry is dropped. The functional unit must hold its stage; the queue does not flag this as an error.
// - Priority at posedge: clear > flush > {enqueue, pop}.
// - flush=1: pointers and occupancy go to 0; any same-cycle enqueue is discarded.
//   - A same-cycle grant still broadcasts the head that cycle. The arbiter must qualify it with flush.
//   - request is 0 from the next cycle.
// - clear mid-operation: identical to reset; in-flight grant discarded.
// CONFIGURATION
// - CDB_BYPASS_EN defined: when occupancy == 0, flush == 0 and fuValid=1:
//   - request=1, result=fuResult, robEntry=fuRob in the same cycle.
//   - If available=1 that cycle, the entry is consumed directly and never written.
//   - Otherwise it is enqueued as normal.
//   - Latency on an empty queue becomes 0 cycles.
// - CDB_BYPASS_EN undefined: no combinational path from fuValid/fuResult to request/result; latency is 1 cycle as above.
// TESTING
// - Reset: clear=1 for 1 cycle -> request=0, occupancy=0, fuReady=1, result=0.
// - Single entry: fuResult=32'd60, fuRob=3'd1, fuValid=1 for 1 cycle, available=0.
//   - Next cycle: request=1, result=60, robEntry=1.
//   - Assert available=1 for 1 cycle -> following cycle request=0, occupancy=0.
// - Fill and wrap: enqueue tags 0..3 with available=0 -> occupancy=4, fuReady=0.
//   - Then hold available=1 while enqueueing tags 4..5 -> bus order 0,1,2,3,4,5 with pointers wrapped; occupancy never exceeds 4.
// - Full with same-cycle pop: occupancy=4, fuValid=1 (tag 7), available=1 -> fuReady=1, occupancy stays 4, tag 7 exits last.
// - Flush: 3 entries queued, flush=1 with fuValid=1 (tag 5) -> next cycle occupancy=0, request=0, and tag 5 never appears.
// - Bypass (CDB_BYPASS_EN): empty queue, fuValid=1, fuResult=32'd99, available=1 -> same cycle request=1, result=99; next cycle occupancy=0.
//   - Without CDB_BYPASS_EN: same stimulus gives request=0 that cycle and request=1, result=99 the next.

Source files
------------

// File: rtl/fu_cdb_request_queue.sv
// CDB transmit-side request queue: buffers {result, ROB tag} from a functional unit
// and presents the oldest entry to the CDB arbiter. Optional macro: CDB_BYPASS_EN.
module fu_cdb_request_queue #(
    parameter int WIDTH = 31,
    parameter int ROB   = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     flush,
    input  logic                     fuValid,
    input  logic [WIDTH:0]           fuResult,
    input  logic [ROB:0]             fuRob,
    output logic                     fuReady,
    output logic                     request,
    output logic [WIDTH:0]           result,
    output logic [ROB:0]             robEntry,
    input  logic                     available,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH:0]  mem_result [DEPTH];
    logic [ROB:0]    mem_rob    [DEPTH];
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [PW-1:0]   head_reg, head_next;
    logic [PW-1:0]   tail_reg, tail_next;
    logic [CW-1:0]   occ_reg, occ_next;

    logic            q_empty;
    logic            grant;
    logic            push_q;
    logic            pop_q;
    logic [WIDTH:0]  head_result;
    logic [ROB:0]    head_rob;
    logic [DEPTH-1:0] wr_sel;
    logic [DEPTH-1:0] rd_sel;

    assign q_empty = (occ_reg == '0);

    // Head data is gated by its valid bit so the bus sees zeros on an empty queue.
    always_comb begin
        head_result = '0;
        head_rob    = '0;
        if (valid_reg[head_reg]) begin
            head_result = mem_result[head_reg];
            head_rob    = mem_rob[head_reg];
        end
    end

`ifdef CDB_BYPASS_EN
    logic bypass;
    assign bypass   = q_empty & ~flush & fuValid;
    assign request  = ~q_empty | bypass;
    assign result   = bypass ? fuResult : head_result;
    assign robEntry = bypass ? fuRob : head_rob;
    assign grant    = request & available;
    assign fuReady  = (occ_reg < DEPTH_C) | grant;
    // A bypassed result that is granted immediately never touches storage.
    assign push_q   = fuValid & fuReady & ~(bypass & available);
`else
    assign request  = ~q_empty;
    assign result   = head_result;
    assign robEntry = head_rob;
    assign grant    = request & available;
    assign fuReady  = (occ_reg < DEPTH_C) | grant;
    assign push_q   = fuValid & fuReady;
`endif

    assign pop_q     = grant & ~q_empty;
    assign occupancy = occ_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign wr_sel[gi] = push_q & (tail_reg == PW'(gi));
            assign rd_sel[gi] = pop_q  & (head_reg == PW'(gi));
        end
    endgenerate

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        occ_next   = occ_reg;
        // On a full queue the popped and written slot coincide; the write wins.
        valid_next = (valid_reg & ~rd_sel) | wr_sel;
        if (push_q)
            tail_next = tail_reg + PW'(1);
        if (pop_q)
            head_next = head_reg + PW'(1);
        if (push_q && !pop_q)
            occ_next = occ_reg + CW'(1);
        else if (pop_q && !push_q)
            occ_next = occ_reg - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (clear || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            occ_reg   <= '0;
            valid_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            occ_reg   <= occ_next;
            valid_reg <= valid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_q && !clear && !flush) begin
            mem_result[tail_reg] <= fuResult;
            mem_rob[tail_reg]    <= fuRob;
        end
    end

endmodule

// File: tb/tb_fu_cdb_request_queue.sv
// Directed vector table plus randomized run against a queue-based reference model
// for fu_cdb_request_queue.
module tb_fu_cdb_request_queue;

`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        clear, flush, fuValid, available;
    logic [31:0] fuResult;
    logic [2:0]  fuRob;
    logic        fuReady, request;
    logic [31:0] result;
    logic [2:0]  robEntry;
    logic [2:0]  occupancy;

    int checks = 0;
    int failures = 0;

    fu_cdb_request_queue #(.WIDTH(31), .ROB(2), .DEPTH(DEPTH)) dut (
        .clk(clk), .clear(clear), .flush(flush), .fuValid(fuValid),
        .fuResult(fuResult), .fuRob(fuRob), .fuReady(fuReady),
        .request(request), .result(result), .robEntry(robEntry),
        .available(available), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr, fl, v;
        logic [31:0] res;
        logic [2:0]  rob;
        logic        av;
        logic        e_req;
        logic [31:0] e_res;
        logic [2:0]  e_rob;
        logic        e_rdy;
        logic [2:0]  e_occ;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [2:0]  t;
    } ent_t;

    vec_t tbl[$];
    ent_t model_q[$];

    function automatic void add(logic clr, logic fl, logic v, logic [31:0] res, logic [2:0] rob,
                                logic av, logic e_req, logic [31:0] e_res, logic [2:0] e_rob,
                                logic e_rdy, logic [2:0] e_occ);
        vec_t x;
        x.clr = clr; x.fl = fl; x.v = v; x.res = res; x.rob = rob; x.av = av;
        x.e_req = e_req; x.e_res = e_res; x.e_rob = e_rob; x.e_rdy = e_rdy; x.e_occ = e_occ;
        tbl.push_back(x);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic clr, input logic fl, input logic v, input logic [31:0] res,
                         input logic [2:0] rob, input logic av);
        clear = clr; flush = fl; fuValid = v; fuResult = res; fuRob = rob; available = av;
    endtask

    initial begin
        logic        m_empty, byp, e_req, grant, e_rdy;
        logic [31:0] e_res;
        logic [2:0]  e_rob;
        logic        r_clr, r_fl, r_v, r_av;
        logic [31:0] r_res;
        logic [2:0]  r_rob;

        drive(1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);

        // reset state
        add(0,0,0,  0,0,0, 0,  0,0,1,0);
        // single entry
        add(0,0,1, 60,1,0, BYP, BYP ? 32'd60 : 32'd0, BYP ? 3'd1 : 3'd0, 1, 0);
        add(0,0,0,  0,0,0, 1, 60,1,1,1);
        add(0,0,0,  0,0,1, 1, 60,1,1,1);
        add(0,0,0,  0,0,0, 0,  0,0,1,0);
        // fill 0..3, then drain while enqueueing 4..5
        add(0,0,1,100,0,0, BYP, BYP ? 32'd100 : 32'd0, 0, 1, 0);
        add(0,0,1,101,1,0, 1,100,0,1,1);
        add(0,0,1,102,2,0, 1,100,0,1,2);
        add(0,0,1,103,3,0, 1,100,0,1,3);
        add(0,0,0,  0,0,0, 1,100,0,0,4);
        add(0,0,1,104,4,1, 1,100,0,1,4);
        add(0,0,1,105,5,1, 1,101,1,1,4);
        add(0,0,0,  0,0,1, 1,102,2,1,4);
        add(0,0,0,  0,0,1, 1,103,3,1,3);
        add(0,0,0,  0,0,1, 1,104,4,1,2);
        add(0,0,0,  0,0,1, 1,105,5,1,1);
        add(0,0,0,  0,0,0, 0,  0,0,1,0);
        // full: dropped tag 6, then same-cycle pop+push of tag 7
        add(0,0,1,100,0,0, BYP, BYP ? 32'd100 : 32'd0, 0, 1, 0);
        add(0,0,1,101,1,0, 1,100,0,1,1);
        add(0,0,1,102,2,0, 1,100,0,1,2);
        add(0,0,1,103,3,0, 1,100,0,1,3);
        add(0,0,1,106,6,0, 1,100,0,0,4);
        add(0,0,1,107,7,1, 1,100,0,1,4);
        add(0,0,0,  0,0,1, 1,101,1,1,4);
        add(0,0,0,  0,0,1, 1,102,2,1,3);
        add(0,0,0,  0,0,1, 1,103,3,1,2);
        add(0,0,0,  0,0,1, 1,107,7,1,1);
        add(0,0,0,  0,0,0, 0,  0,0,1,0);
        // flush with same-cycle enqueue of tag 5
        add(0,0,1,101,1,0, BYP, BYP ? 32'd101 : 32'd0, BYP ? 3'd1 : 3'd0, 1, 0);
        add(0,0,1,102,2,0, 1,101,1,1,1);
        add(0,0,1,103,3,0, 1,101,1,1,2);
        add(0,1,1,105,5,0, 1,101,1,1,3);
        add(0,0,0,  0,0,0, 0,  0,0,1,0);
        // empty queue, result 99 with grant
        add(0,0,1, 99,4,1, BYP, BYP ? 32'd99 : 32'd0, BYP ? 3'd4 : 3'd0, 1, 0);
        add(0,0,0,  0,0,0, !BYP, BYP ? 32'd0 : 32'd99, BYP ? 3'd0 : 3'd4, 1, BYP ? 3'd0 : 3'd1);
        add(0,0,0,  0,0,1, !BYP, BYP ? 32'd0 : 32'd99, BYP ? 3'd0 : 3'd4, 1, BYP ? 3'd0 : 3'd1);
        add(0,0,0,  0,0,0, 0,  0,0,1,0);
        // grant with nothing requested is ignored
        add(0,0,0,  0,0,1, 0,  0,0,1,0);
        add(0,0,0,  0,0,0, 0,  0,0,1,0);
        // clear mid-operation discards in-flight grant
        add(0,0,1,101,1,0, BYP, BYP ? 32'd101 : 32'd0, BYP ? 3'd1 : 3'd0, 1, 0);
        add(0,0,1,102,2,0, 1,101,1,1,1);
        add(1,0,0,  0,0,1, 1,101,1,1,2);
        add(0,0,0,  0,0,0, 0,  0,0,1,0);

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].fl, tbl[i].v, tbl[i].res, tbl[i].rob, tbl[i].av);
            #1;
            $display("vec %0d: clr=%0d fl=%0d v=%0d res=%0d rob=%0d av=%0d -> req=%0d res=%0d rob=%0d rdy=%0d occ=%0d",
                     i, tbl[i].clr, tbl[i].fl, tbl[i].v, tbl[i].res, tbl[i].rob, tbl[i].av,
                     request, result, robEntry, fuReady, occupancy);
            check($sformatf("vec%0d_request", i),   64'(request),   64'(tbl[i].e_req));
            check($sformatf("vec%0d_result", i),    64'(result),    64'(tbl[i].e_res));
            check($sformatf("vec%0d_robEntry", i),  64'(robEntry),  64'(tbl[i].e_rob));
            check($sformatf("vec%0d_fuReady", i),   64'(fuReady),   64'(tbl[i].e_rdy));
            check($sformatf("vec%0d_occupancy", i), 64'(occupancy), 64'(tbl[i].e_occ));
            @(posedge clk);
            @(negedge clk);
        end

        // Randomized phase: model is a plain FIFO of {result, tag}; queue is empty here.
        model_q.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            r_clr = ($urandom_range(0, 49) == 0);
            r_fl  = ($urandom_range(0, 15) == 0);
            r_v   = $urandom_range(0, 1) == 1;
            r_av  = $urandom_range(0, 2) != 0;
            r_res = $urandom;
            r_rob = 3'($urandom_range(0, 7));
            drive(r_clr, r_fl, r_v, r_res, r_rob, r_av);
            #1;
            m_empty = (model_q.size() == 0);
            byp     = BYP && m_empty && !r_fl && r_v;
            e_req   = !m_empty || byp;
            e_res   = byp ? r_res : (m_empty ? 32'd0 : model_q[0].r);
            e_rob   = byp ? r_rob : (m_empty ? 3'd0 : model_q[0].t);
            grant   = e_req && r_av;
            e_rdy   = (model_q.size() < DEPTH) || grant;
            check("rnd_request",   64'(request),   64'(e_req));
            check("rnd_result",    64'(result),    64'(e_res));
            check("rnd_robEntry",  64'(robEntry),  64'(e_rob));
            check("rnd_fuReady",   64'(fuReady),   64'(e_rdy));
            check("rnd_occupancy", 64'(occupancy), 64'(model_q.size()));
            if (grant)
                $display("rnd %0d: bus res=%0h rob=%0d clr=%0d fl=%0d", cyc, e_res, e_rob, r_clr, r_fl);
            @(posedge clk);
            if (r_clr || r_fl) begin
                model_q.delete();
            end else begin
                ent_t e;
                if (grant && !m_empty)
                    void'(model_q.pop_front());
                if (r_v && e_rdy && !(byp && r_av)) begin
                    e.r = r_res;
                    e.t = r_rob;
                    model_q.push_back(e);
                end
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
